pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries a control bundle and a data bundle with a valid/ready handshake, and stalls without dropping data. On flush it inserts a bubble with a defined control pattern, so no write enables leak downstream. One instance sits between each pair of pipeline stages; a hazard unit drives Flush.

## Interface
- DATA_W, 32: width of data bundle (operands, PC, immediates).
- CTRL_W, 16: width of control bundle (ALU op, RF/HI/LO/MEM enables, size, sign).
- BUBBLE_CTRL, {CTRL_W{1'b0}}: control value presented for a bubble (all enables deasserted).
- CNT_W, 16: width of stall counter.

- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Flush  in  1  discard all held entries this cycle.
- In_Valid  in  1  upstream entry valid.
- In_Ready  out  1  stage can accept this cycle.
- In_Ctrl  in  CTRL_W  upstream control bundle.
- In_Data  in  DATA_W  upstream data bundle.
- Out_Valid  out  1  Out_Ctrl/Out_Data hold a real entry.
- Out_Ready  in  1  downstream accepts this cycle.
- Out_Ctrl  out  CTRL_W  control bundle; BUBBLE_CTRL whenever Out_Valid=0.
- Out_Data  out  DATA_W  data bundle.
- Stall_Count  out  CNT_W  saturating count of cycles with Out_Valid=1 and Out_Ready=0.

## Operation
- Accept = In_Valid & In_Ready; Emit = Out_Valid & Out_Ready.
- Entry ordering is strict FIFO. No entry is duplicated or lost except by Flush.
- State machine (skid build): EMPTY, BUSY (main entry held), FULL (main + skid held).
  - EMPTY: Accept -> BUSY.
  - BUSY: Accept & !Out_Ready -> FULL (input goes to skid). Accept & Out_Ready -> BUSY (main replaced). !Accept & Out_Ready -> EMPTY.
  - FULL: Out_Ready -> BUSY (skid moves to main). In_Ready=0, so no Accept is possible.
- Flush: next state EMPTY from any state. A simultaneous Accept is discarded. Out_Ctrl=BUBBLE_CTRL from the next cycle. Data registers are not cleared on flush.
- Stall_Count increments when Out_Valid & !Out_Ready and saturates at all-ones. Only reset clears it; Flush does not.
- Out_Ctrl is forced to BUBBLE_CTRL by muxing on Out_Valid, so a bubble never carries stale enables.

## Timing
- Latency: Accept in cycle N makes the entry visible on Out_* in cycle N+1.
- Throughput: 1 entry/cycle sustained while Out_Ready=1.
- In_Ready (skid build) is a registered output, (state != FULL), with no combinational path from Out_Ready.
- In_Ready (non-skid build) = !Out_Valid | Out_Ready, which is combinational.
- Reset (asynchronous assert, synchronous deassert by the system):
  - Out_Valid=0, Out_Ctrl=BUBBLE_CTRL, Out_Data=0, Stall_Count=0.
  - In_Ready=1, state EMPTY, skid entry cleared.
- Reset asserted mid-transfer loses all held entries; this is the required behaviour.
- Out_Ready=1 while Out_Valid=0 is legal and has no effect.
- Flush has priority over Accept and Emit in the same cycle.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry skid buffer and registered In_Ready. The stage tolerates one cycle of Out_Ready deassertion without throttling upstream timing.
- PIPE_STAGE_SKID_EN undefined:
  - Single register; states EMPTY/BUSY only.
  - In_Ready is combinational as above.
  - Same latency, ordering and flush semantics.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY, BUSY, FULL);
  - default bubble constant PIPE_BUBBLE_CTRL;
  - per-stage CTRL_W/DATA_W localparams for IF/ID, ID/EX, EX/MEM and MEM/WB.
- One sub-module: pipe_skid_entry, a holding register for {ctrl, data} with load/clear. Instantiate it twice for the skid build and once for the non-skid build.

## Test plan
- Reset, then In_Valid=1, In_Ctrl=16'h00A5, In_Data=32'h1234_5678, Out_Ready=1 for one cycle -> next cycle Out_Valid=1, Out_Ctrl=16'h00A5, Out_Data=32'h1234_5678.
- Stream 8 entries (Data 0..7) with Out_Ready=1 -> 8 consecutive outputs in order, no gaps, In_Ready stays 1.
- Skid build, BUSY holding Data=1: Out_Ready=0 for 3 cycles while offering Data=2,3 -> Data=2 stored, In_Ready=0, Stall_Count=3. After Out_Ready=1, outputs are 1, 2, 3 in order.
- FULL state with Flush=1 and In_Valid=1 in the same cycle -> next cycle Out_Valid=0, Out_Ctrl=BUBBLE_CTRL, In_Ready=1, and the offered entry is never emitted.
- Hold Out_Valid=1 with Out_Ready=0 for 2^CNT_W+5 cycles -> Stall_Count saturates at all-ones. Assert Reset_n=0 mid-cycle -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
package pipe_pkg;

  // Stage occupancy: nothing held, main entry held, main and skid entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_CTRL_W = 16;
  localparam int unsigned PIPE_DATA_W = 32;

  // Bubble control pattern: every enable deasserted.
  localparam logic [PIPE_CTRL_W-1:0] PIPE_BUBBLE_CTRL = '0;

  // Per-stage bundle widths.
  localparam int unsigned IFID_CTRL_W  = 4;
  localparam int unsigned IFID_DATA_W  = 64;   // PC + instruction
  localparam int unsigned IDEX_CTRL_W  = 16;
  localparam int unsigned IDEX_DATA_W  = 128;  // PC + rs + rt + immediate
  localparam int unsigned EXMEM_CTRL_W = 10;
  localparam int unsigned EXMEM_DATA_W = 64;   // ALU result + store data
  localparam int unsigned MEMWB_CTRL_W = 4;
  localparam int unsigned MEMWB_DATA_W = 32;   // write-back value

endpackage

// File: rtl/pipe_skid_entry.sv
// Holding register for one {ctrl, data} entry. Clear only returns the control
// field to the bubble pattern; the data field keeps its last value.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W      = 16,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Control field: clear wins over load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      ctrl_q <= BUBBLE_CTRL;
    else if (clear_i) ctrl_q <= BUBBLE_CTRL;
    else if (load_i)  ctrl_q <= ctrl_i;
  end

  // Data field: not touched by clear, and never loaded in a clearing cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 data_q <= '0;
    else if (load_i && !clear_i) data_q <= data_i;
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with flush-to-bubble.
// Build option PIPE_STAGE_SKID_EN: adds a skid entry and a registered In_Ready.
//
//   state    | meaning
//   EMPTY    | nothing held, Out_Valid=0
//   BUSY     | main entry held and presented
//   FULL     | main presented, skid holds the next entry (skid build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  Stall_Count
);

  pipe_state_e       state_q, state_d;
  logic              accept;
  logic              main_load;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q;
  logic [DATA_W-1:0] main_data_d, main_data_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign Out_Valid = (state_q != ST_EMPTY);
  assign accept    = In_Valid & In_Ready;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load;
  logic              main_from_skid;
  logic              in_ready_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  // Next state and entry routing; flush discards everything including a same-cycle accept.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d   = ST_BUSY;
          main_load = 1'b1;
        end
        ST_BUSY: begin
          if (accept && Out_Ready) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (Out_Ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (Out_Ready) begin
          state_d        = ST_BUSY;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // In_Ready comes straight from a flop, so Out_Ready never reaches it combinationally.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) in_ready_q <= 1'b1;
    else          in_ready_q <= (state_d != ST_FULL);
  end

  assign In_Ready    = in_ready_q;
  assign main_ctrl_d = main_from_skid ? skid_ctrl_q : In_Ctrl;
  assign main_data_d = main_from_skid ? skid_data_q : In_Data;

  pipe_skid_entry #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_skid (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .load_i  (skid_load),
    .clear_i (Flush),
    .ctrl_i  (In_Ctrl),
    .data_i  (In_Data),
    .ctrl_o  (skid_ctrl_q),
    .data_o  (skid_data_q)
  );
`else
  // Next state for the single-register build; flush has priority.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d   = ST_BUSY;
      main_load = 1'b1;
    end else if (Out_Ready) begin
      state_d = ST_EMPTY;
    end
  end

  assign In_Ready    = !Out_Valid | Out_Ready;
  assign main_ctrl_d = In_Ctrl;
  assign main_data_d = In_Data;
`endif

  pipe_skid_entry #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_main (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .load_i  (main_load),
    .clear_i (Flush),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .ctrl_o  (main_ctrl_q),
    .data_o  (main_data_q)
  );

  // Saturating count of cycles where a valid entry is held back by downstream.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Out_Valid && !Out_Ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign Out_Ctrl    = Out_Valid ? main_ctrl_q : BUBBLE_CTRL;
  assign Out_Data    = main_data_q;
  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, checked
// against a FIFO-queue model of the stage. Follows PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int unsigned CNT_MAX = 65535;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] In_Ctrl;
  logic [31:0] In_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Ctrl;
  logic [31:0] Out_Data;
  logic [15:0] Stall_Count;

  int checks   = 0;
  int failures = 0;

  logic [47:0] mq[$];
  int unsigned stall_m;

  always #5 Clk = ~Clk;

  pipe_stage_reg dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Flush       (Flush),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .In_Ctrl     (In_Ctrl),
    .In_Data     (In_Data),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .Out_Ctrl    (Out_Ctrl),
    .Out_Data    (Out_Data),
    .Stall_Count (Stall_Count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || Out_Ready;
`endif
  endfunction

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic cyc();
    logic acc, emit;
    @(negedge Clk);
    chk("out_valid", 64'(Out_Valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(In_Ready), 64'(model_ready()));
    chk("out_ctrl", 64'(Out_Ctrl), (mq.size() > 0) ? 64'(mq[0][47:32]) : 64'h0);
    if (mq.size() > 0) chk("out_data", 64'(Out_Data), 64'(mq[0][31:0]));
    chk("stall_count", 64'(Stall_Count), 64'(stall_m));
    acc  = In_Valid && model_ready() && !Flush;
    emit = (mq.size() > 0) && Out_Ready;
    if ((mq.size() > 0) && !Out_Ready && (stall_m != CNT_MAX)) stall_m++;
    @(posedge Clk);
    if (Flush) mq.delete();
    else begin
      if (emit) void'(mq.pop_front());
      if (acc) mq.push_back({In_Ctrl, In_Data});
    end
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    In_Ctrl = '0; In_Data = '0;
    stall_m = 0;
    #12;
    chk("rst_out_valid", 64'(Out_Valid), 64'h0);
    chk("rst_in_ready", 64'(In_Ready), 64'h1);
    chk("rst_out_ctrl", 64'(Out_Ctrl), 64'h0);
    chk("rst_out_data", 64'(Out_Data), 64'h0);
    chk("rst_stall", 64'(Stall_Count), 64'h0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Single transfer, one-cycle latency.
    In_Valid = 1'b1; In_Ctrl = 16'h00A5; In_Data = 32'h1234_5678; Out_Ready = 1'b1;
    cyc();
    In_Valid = 1'b0;
    chk("t1_valid", 64'(Out_Valid), 64'h1);
    chk("t1_ctrl", 64'(Out_Ctrl), 64'h00A5);
    chk("t1_data", 64'(Out_Data), 64'h1234_5678);
    cyc();

    // Back-to-back stream of 8 entries.
    for (int i = 0; i < 8; i++) begin
      In_Valid = 1'b1; In_Data = 32'(i); In_Ctrl = 16'($urandom);
      chk("stream_in_ready", 64'(In_Ready), 64'h1);
      cyc();
      chk("stream_valid", 64'(Out_Valid), 64'h1);
      chk("stream_data", 64'(Out_Data), 64'(i));
    end
    In_Valid = 1'b0;
    cyc();

    // Downstream stall with upstream still offering entries.
    In_Valid = 1'b1; In_Data = 32'd1; In_Ctrl = 16'h0001; Out_Ready = 1'b1;
    cyc();
    Out_Ready = 1'b0; In_Data = 32'd2; In_Ctrl = 16'h0002;
    cyc();
    In_Data = 32'd3; In_Ctrl = 16'h0003;
    cyc();
    cyc();
    chk("stall_3", 64'(Stall_Count), 64'd3);
    chk("stall_in_ready", 64'(In_Ready), 64'h0);
    Out_Ready = 1'b1;
    chk("order_1", 64'(Out_Data), 64'd1);
    cyc();
`ifdef PIPE_STAGE_SKID_EN
    chk("order_2", 64'(Out_Data), 64'd2);
    cyc();
`endif
    chk("order_3", 64'(Out_Data), 64'd3);
    In_Valid = 1'b0;
    cyc();
    cyc();

    // Flush while holding entries, with a simultaneous offer.
    Out_Ready = 1'b0; In_Valid = 1'b1; In_Data = 32'hAAAA; In_Ctrl = 16'h0F0F;
    cyc();
    In_Data = 32'hBBBB; In_Ctrl = 16'hF0F0;
    cyc();
    Flush = 1'b1; In_Data = 32'hCCCC; In_Ctrl = 16'h3C3C;
    cyc();
    Flush = 1'b0; In_Valid = 1'b0;
    chk("flush_valid", 64'(Out_Valid), 64'h0);
    chk("flush_ctrl", 64'(Out_Ctrl), 64'h0);
    chk("flush_in_ready", 64'(In_Ready), 64'h1);
    Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      In_Valid  = 1'($urandom_range(0, 3) != 0);
      Out_Ready = 1'($urandom_range(0, 2) != 0);
      Flush     = 1'($urandom_range(0, 19) == 0);
      In_Ctrl   = 16'($urandom);
      In_Data   = $urandom;
      cyc();
    end
    Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    cyc();
    cyc();

    // Long stall to saturate the counter, then asynchronous reset mid-cycle.
    In_Valid = 1'b1; In_Ctrl = 16'h5A5A; In_Data = 32'hDEAD_BEEF;
    cyc();
    In_Valid = 1'b0; Out_Ready = 1'b0;
    for (int i = 0; i < 65541; i++) cyc();
    chk("stall_sat", 64'(Stall_Count), 64'hFFFF);
    chk("sat_held_ctrl", 64'(Out_Ctrl), 64'h5A5A);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(Out_Valid), 64'h0);
    chk("async_in_ready", 64'(In_Ready), 64'h1);
    chk("async_out_ctrl", 64'(Out_Ctrl), 64'h0);
    chk("async_out_data", 64'(Out_Data), 64'h0);
    chk("async_stall", 64'(Stall_Count), 64'h0);
    mq.delete();
    stall_m = 0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    Out_Ready = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
